// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store front end onto a word-wide memory.
// Sub-word stores use a two-cycle read-modify-write with a one-cycle stall.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        fault_sticky,
  output logic [15:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic {
    IDLE,
    MERGE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_old_word;
  logic        r_fault_sticky;

  logic        w_bad;
  logic        w_capture;
  logic [1:0]  w_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign mem_a        = req_addr[15:0];
  assign w_lane       = req_addr[1:0];
  assign fault_sticky = r_fault_sticky;

  always_comb begin
    w_bad = (req_addr[31:16] != 16'h0);
    unique case (req_funct3)
      3'b000, 3'b100: ;
      3'b001, 3'b101: if (req_addr[0]) w_bad = 1'b1;
      3'b010:         if (w_lane != 2'b00) w_bad = 1'b1;
      default:        w_bad = 1'b1;
    endcase
    // unsigned variants exist only for loads
    if (req_we && req_funct3[2]) w_bad = 1'b1;
  end

  always_comb begin
    w_byte = mem_rd[{w_lane, 3'b000} +: 8];
    w_half = req_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    unique case (req_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = mem_rd;
    endcase
  end

  always_comb begin
    w_merge = r_old_word;
    if (req_funct3[0])
      w_merge[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
    else
      w_merge[{w_lane, 3'b000} +: 8] = req_wdata[7:0];
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    rdata     = 32'h0;
    stall     = 1'b0;
    fault     = 1'b0;
    mem_we    = 1'b0;
    mem_wd    = req_wdata;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (req) begin
            if (w_bad) begin
              fault = 1'b1;
            end else if (!req_we) begin
              rdata = w_load;
            end else if (req_funct3 == 3'b010) begin
              mem_we = 1'b1;
            end else begin
              stall     = 1'b1;
              w_capture = 1'b1;
              w_next    = MERGE;
            end
          end
        end
        MERGE: begin
          w_next = IDLE;
          // dropped request aborts the merge without writing
          if (req) begin
            mem_we = 1'b1;
            mem_wd = w_merge;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_old_word     <= 32'h0;
      r_fault_sticky <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_capture) r_old_word <= mem_rd;
      if (fault) r_fault_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench with a behavioural
// word memory attached to the memory port.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;
  logic        fault_sticky;
  logic [15:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:16383];

  int nerr = 0;
  int nchk = 0;
  logic sk_model = 1'b0;
  logic sk_valid = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        st;
    logic        ft;
    logic        we;
    logic [31:0] wd;
    logic        sk;
    logic        cks;
  } exp_t;

  exp_t q[$];

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rdata        (rdata),
    .stall        (stall),
    .fault        (fault),
    .fault_sticky (fault_sticky),
    .mem_a        (mem_a),
    .mem_we       (mem_we),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rd = mem[mem_a[15:2]];

  always @(posedge clk)
    if (mem_we) mem[mem_a[15:2]] <= mem_wd;

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s.%s got=%h exp=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic rq,
                     input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] erd, input logic est,
                     input logic eft, input logic ewe,
                     input logic [31:0] ewd);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    req        = rq;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    e.tag = tag; e.rd = erd; e.st = est; e.ft = eft;
    e.we = ewe; e.wd = ewd; e.sk = sk_model; e.cks = sk_valid;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    chk(e.tag, "rdata", rdata, e.rd);
    chk(e.tag, "stall", {31'h0, stall}, {31'h0, e.st});
    chk(e.tag, "fault", {31'h0, fault}, {31'h0, e.ft});
    chk(e.tag, "mem_we", {31'h0, mem_we}, {31'h0, e.we});
    if (e.we) chk(e.tag, "mem_wd", mem_wd, e.wd);
    if (e.cks)
      chk(e.tag, "sticky", {31'h0, fault_sticky}, {31'h0, e.sk});
    if (r) sk_model = 1'b0;
    else if (eft) sk_model = 1'b1;
    sk_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;

    cyc("rst0", 1, 1, 1, 3'b000, 32'h300, 32'h0, 0, 0, 0, 0, 0);
    cyc("rst1", 1, 1, 1, 3'b000, 32'h300, 32'h0, 0, 0, 0, 0, 0);

    cyc("sw40", 0, 1, 1, 3'b010, 32'h40, 32'h8899AABB,
        0, 0, 0, 1, 32'h8899AABB);
    cyc("lb41", 0, 1, 0, 3'b000, 32'h41, 0, 32'hFFFFFFAA, 0, 0, 0, 0);
    cyc("lbu41", 0, 1, 0, 3'b100, 32'h41, 0, 32'h000000AA, 0, 0, 0, 0);
    cyc("lh42", 0, 1, 0, 3'b001, 32'h42, 0, 32'hFFFF8899, 0, 0, 0, 0);
    cyc("lhu42", 0, 1, 0, 3'b101, 32'h42, 0, 32'h00008899, 0, 0, 0, 0);
    cyc("lb40", 0, 1, 0, 3'b000, 32'h40, 0, 32'hFFFFFFBB, 0, 0, 0, 0);

    cyc("sw100", 0, 1, 1, 3'b010, 32'h100, 32'h12345678,
        0, 0, 0, 1, 32'h12345678);
    cyc("lw100", 0, 1, 0, 3'b010, 32'h100, 0, 32'h12345678, 0, 0, 0, 0);

    cyc("sw200", 0, 1, 1, 3'b010, 32'h200, 32'h11223344,
        0, 0, 0, 1, 32'h11223344);
    cyc("sb202a", 0, 1, 1, 3'b000, 32'h202, 32'hDEADBEEF, 0, 1, 0, 0, 0);
    cyc("sb202b", 0, 1, 1, 3'b000, 32'h202, 32'hDEADBEEF,
        0, 0, 0, 1, 32'h11EF3344);
    cyc("lw200a", 0, 1, 0, 3'b010, 32'h200, 0, 32'h11EF3344, 0, 0, 0, 0);
    cyc("sh200a", 0, 1, 1, 3'b001, 32'h200, 32'h0000CAFE, 0, 1, 0, 0, 0);
    cyc("sh200b", 0, 1, 1, 3'b001, 32'h200, 32'h0000CAFE,
        0, 0, 0, 1, 32'h11EFCAFE);
    cyc("lw200b", 0, 1, 0, 3'b010, 32'h200, 0, 32'h11EFCAFE, 0, 0, 0, 0);

    cyc("f_lw103", 0, 1, 0, 3'b010, 32'h103, 0, 0, 0, 1, 0, 0);
    cyc("f_sh101", 0, 1, 1, 3'b001, 32'h101, 32'h55, 0, 0, 1, 0, 0);
    cyc("f_range", 0, 1, 0, 3'b010, 32'h00010000, 0, 0, 0, 1, 0, 0);
    cyc("f_f3_011", 0, 1, 0, 3'b011, 32'h40, 0, 0, 0, 1, 0, 0);
    cyc("f_sbu", 0, 1, 1, 3'b100, 32'h40, 32'h1, 0, 0, 1, 0, 0);
    cyc("idle", 0, 0, 0, 3'b010, 32'h40, 0, 0, 0, 0, 0, 0);

    cyc("sw300", 0, 1, 1, 3'b010, 32'h300, 32'hA5A5A5A5,
        0, 0, 0, 1, 32'hA5A5A5A5);
    cyc("sb300a", 0, 1, 1, 3'b000, 32'h300, 32'h77, 0, 1, 0, 0, 0);
    cyc("sb300rst", 1, 1, 1, 3'b000, 32'h300, 32'h77, 0, 0, 0, 0, 0);
    cyc("postrst", 0, 0, 0, 3'b000, 32'h300, 0, 0, 0, 0, 0, 0);
    chk("rstmerge", "mem300", mem[16'h300 >> 2], 32'hA5A5A5A5);
    cyc("lw300a", 0, 1, 0, 3'b010, 32'h300, 0, 32'hA5A5A5A5, 0, 0, 0, 0);

    cyc("sb301a", 0, 1, 1, 3'b000, 32'h301, 32'h80, 0, 1, 0, 0, 0);
    cyc("sb301b", 0, 1, 1, 3'b000, 32'h301, 32'h80,
        0, 0, 0, 1, 32'hA5A580A5);
    cyc("lb301", 0, 1, 0, 3'b000, 32'h301, 0, 32'hFFFFFF80, 0, 0, 0, 0);

    cyc("sb302a", 0, 1, 1, 3'b000, 32'h302, 32'h11, 0, 1, 0, 0, 0);
    cyc("sb302abt", 0, 0, 1, 3'b000, 32'h302, 32'h11, 0, 0, 0, 0, 0);
    cyc("lw300b", 0, 1, 0, 3'b010, 32'h300, 0, 32'hA5A580A5, 0, 0, 0, 0);
    chk("abort", "mem300", mem[16'h300 >> 2], 32'hA5A580A5);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
